digital_clock: RTL and testbench



---
 rtl/digital_clock.sv | 70 +++++++
 tb/tb_digital_clock.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/digital_clock.sv
// 24-hour time-of-day counter: a prescaler produces a one-second tick that
// advances cascaded mod-60 / mod-60 / mod-24 binary counters.
`timescale 1ns/1ps
module digital_clock #(
    parameter int unsigned CLKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr
);

    localparam int unsigned          PW       = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0]        PRE_LAST = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q,  hr_d;
    logic          tick;
    logic          sec_carry;
    logic          min_carry;

    // With CLKS_PER_SEC=1 pre_q stays 0 and matches PRE_LAST, so tick is constant 1.
    assign tick      = (pre_q == PRE_LAST);
    assign pre_d     = tick ? '0 : pre_q + PW'(1);

    assign sec_carry = (sec_q == 6'd59);
    assign min_carry = sec_carry && (min_q == 6'd59);

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (tick) begin
            sec_d = (sec_q >= 6'd59) ? '0 : sec_q + 6'd1;

            // Out-of-range values reload 0 on any tick, independent of carries.
            if (min_q > 6'd59)
                min_d = '0;
            else if (sec_carry)
                min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;

            if (hr_q > 5'd23)
                hr_d = '0;
            else if (min_carry)
                hr_d = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    assign sec = sec_q;
    assign min = min_q;
    assign hr  = hr_q;

endmodule

// File: tb/tb_digital_clock.sv
// Bench for digital_clock: two instances (1 and 4 clocks per second) on one
// clock, compared against elapsed-seconds arithmetic.
`timescale 1ns/1ps
module tb_digital_clock;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec1, min1, sec4, min4;
    logic [4:0] hr1, hr4;

    int n_checks = 0;
    int n_pass   = 0;
    int edges    = 0;
    int bad      = 0;

    always #5 clk = ~clk;

    digital_clock #(.CLKS_PER_SEC(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .sec (sec1),
        .min (min1),
        .hr  (hr1)
    );

    digital_clock #(.CLKS_PER_SEC(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .sec (sec4),
        .min (min4),
        .hr  (hr4)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Expected time shown as hhmmss decimal after t whole seconds.
    function automatic int tod_exp(input int t);
        return ((t / 3600) % 24) * 10000 + ((t / 60) % 60) * 100 + (t % 60);
    endfunction

    function automatic int tod1();
        return int'(hr1) * 10000 + int'(min1) * 100 + int'(sec1);
    endfunction

    function automatic int tod4();
        return int'(hr4) * 10000 + int'(min4) * 100 + int'(sec4);
    endfunction

    // One counted rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        edges++;
        #1;
        if (sec1 > 6'd59 || min1 > 6'd59 || hr1 > 5'd23) bad++;
        if (sec4 > 6'd59 || min4 > 6'd59 || hr4 > 5'd23) bad++;
    endtask

    task automatic check_both(input string tag);
        check($sformatf("%s_c1_e%0d", tag, edges), tod1(), tod_exp(edges));
        check($sformatf("%s_c4_e%0d", tag, edges), tod4(), tod_exp(edges / 4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #3;
        check("rst_async_c1", tod1(), 0);
        check("rst_async_c4", tod4(), 0);
        repeat (9) begin
            @(negedge clk);
            check("rst_held_c1", tod1(), 0);
            check("rst_held_c4", tod4(), 0);
        end
        #10;
        rst = 1'b0;

        step();
        check("first_edge_c1", tod1(), 1);
        check("first_edge_c4", tod4(), 0);

        while (edges < 86400 + 3723) begin
            step();
            if (edges <= 16)
                check_both("presc");
            else if (edges == 59 || edges == 60 || edges == 3599 || edges == 3600 ||
                     edges == 86399 || edges == 86400)
                check_both("carry");
            else if ($urandom_range(0, 255) == 0)
                check_both("rand");
        end
        check("at_010203", tod1(), 10203);

        // Asynchronous clear between edges, before any further clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("mid_clr_c1", tod1(), 0);
        check("mid_clr_c4", tod4(), 0);
        @(posedge clk);
        #1;
        check("mid_hold_c1", tod1(), 0);
        check("mid_hold_c4", tod4(), 0);
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        step();
        check("restart_c1", tod1(), 1);
        check("restart_c4", tod4(), 0);

        repeat (3) begin
            int n;
            n = int'($urandom_range(1, 400));
            repeat (n) begin
                step();
                check_both("run");
            end
            #($urandom_range(1, 7));
            rst = 1'b1;
            #1;
            check("rand_clr_c1", tod1(), 0);
            check("rand_clr_c4", tod4(), 0);
            @(negedge clk);
            rst   = 1'b0;
            edges = 0;
        end
        step();
        check_both("final");

        check("out_of_range_seen", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
